// File: rtl/ps2_key_ctrl_if.sv
// Scancode-in / key-event-out bundle between the PS/2 receiver, the sequencer and its consumers.
interface ps2_key_ctrl_if #(
    parameter int DEPTH = 8
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          ev_ready;
    logic          ovf_clr;
    logic          ev_valid;
    logic [7:0]    ev_code;
    logic          ev_ext;
    logic          ev_break;
    logic          ev_repeat;
    logic [LW-1:0] fifo_level;
    logic          overflow;
    logic          shift;
    logic          ctrl;
    logic          caps_lock;

    modport master (
        output rx_data, rx_valid, ev_ready, ovf_clr,
        input  ev_valid, ev_code, ev_ext, ev_break, ev_repeat,
        input  fifo_level, overflow, shift, ctrl, caps_lock
    );

    modport slave (
        input  rx_data, rx_valid, ev_ready, ovf_clr,
        output ev_valid, ev_code, ev_ext, ev_break, ev_repeat,
        output fifo_level, overflow, shift, ctrl, caps_lock
    );
endinterface

// File: rtl/ps2_key_ctrl.sv
// Folds E0/F0 prefixes into key events, tracks modifiers/repeat, queues events in a FWFT FIFO.
// One cycle from rx_valid to ev_valid; events arriving while the FIFO is full (and not popping) are dropped.
module ps2_key_ctrl #(
    parameter int DEPTH       = 8,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic          clk,
    input  logic          resetn,
    ps2_key_ctrl_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_E0, S_F0, S_E0F0} state_t;
    typedef struct packed {
        logic       rpt;
        logic       brk;
        logic       ext;
        logic [7:0] code;
    } ev_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          is_e0, is_f0, is_ctl, tmo_hit;
    logic          gen_ev, cur_ext, cur_brk, cur_rpt, lm_hit;
    logic          lm_vld_q, lm_ext_q;
    logic [7:0]    lm_code_q;
    logic          lshift_q, rshift_q, lctrl_q, rctrl_q, caps_q, ovf_q;
    ev_t           mem_q [DEPTH];
    ev_t           head, wr_word;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q, level_d;
    logic          full, empty, push, pop, drop;

    assign is_e0   = bus.rx_data == 8'hE0;
    assign is_f0   = bus.rx_data == 8'hF0;
    assign is_ctl  = bus.rx_data inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
    assign tmo_hit = (state_q != S_IDLE) && (tmo_q == TMO_LAST);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
        end
    end

    // A byte arriving on the timeout cycle still counts against the pending prefix.
    always_comb begin
        state_d = state_q;
        tmo_d   = (bus.rx_valid || state_q == S_IDLE || tmo_hit) ? '0 : tmo_q + TW'(1);
        if (bus.rx_valid) begin
            if (is_e0)
                state_d = S_E0;
            else if (is_f0)
                state_d = (state_q == S_E0 || state_q == S_E0F0) ? S_E0F0 : S_F0;
            else
                state_d = S_IDLE;
        end else if (tmo_hit) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        gen_ev  = 1'b0;
        cur_ext = 1'b0;
        cur_brk = 1'b0;
        if (bus.rx_valid && !is_e0 && !is_f0 && !is_ctl) begin
            gen_ev  = 1'b1;
            cur_ext = (state_q == S_E0) || (state_q == S_E0F0);
            cur_brk = (state_q == S_F0) || (state_q == S_E0F0);
        end
    end

    assign lm_hit  = lm_vld_q && (lm_ext_q == cur_ext) && (lm_code_q == bus.rx_data);
    assign cur_rpt = !cur_brk && lm_hit;
    assign wr_word = {cur_rpt, cur_brk, cur_ext, bus.rx_data};

    // Key-state tracking follows every generated event, including dropped ones.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            lm_vld_q  <= 1'b0;
            lm_ext_q  <= 1'b0;
            lm_code_q <= '0;
            lshift_q  <= 1'b0;
            rshift_q  <= 1'b0;
            lctrl_q   <= 1'b0;
            rctrl_q   <= 1'b0;
            caps_q    <= 1'b0;
        end else if (gen_ev) begin
            if (!cur_brk && !lm_hit) begin
                lm_vld_q  <= 1'b1;
                lm_ext_q  <= cur_ext;
                lm_code_q <= bus.rx_data;
            end else if (cur_brk && lm_hit) begin
                lm_vld_q  <= 1'b0;
            end
            if (!cur_ext && bus.rx_data == 8'h12) lshift_q <= !cur_brk;
            if (!cur_ext && bus.rx_data == 8'h59) rshift_q <= !cur_brk;
            if (!cur_ext && bus.rx_data == 8'h14) lctrl_q  <= !cur_brk;
            if ( cur_ext && bus.rx_data == 8'h14) rctrl_q  <= !cur_brk;
            if (!cur_ext && !cur_brk && !cur_rpt && bus.rx_data == 8'h58) caps_q <= !caps_q;
        end
    end

    assign full  = level_q == LW'(DEPTH);
    assign empty = level_q == '0;
    assign pop   = !empty && bus.ev_ready;
    assign push  = gen_ev && (!full || pop);
    assign drop  = gen_ev && full && !pop;

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_d;
            if (drop)             ovf_q <= 1'b1;
            else if (bus.ovf_clr) ovf_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_word;
    end

    assign head           = mem_q[rd_ptr_q];
    assign bus.ev_valid   = !empty;
    assign bus.ev_code    = empty ? 8'h00 : head.code;
    assign bus.ev_ext     = !empty && head.ext;
    assign bus.ev_break   = !empty && head.brk;
    assign bus.ev_repeat  = !empty && head.rpt;
    assign bus.fifo_level = level_q;
    assign bus.overflow   = ovf_q;
    assign bus.shift      = lshift_q || rshift_q;
    assign bus.ctrl       = lctrl_q || rctrl_q;
    assign bus.caps_lock  = caps_q;
endmodule
